mano_mem_responder: RTL and testbench
=====================================

MANO_MEM_RESPONDER -- requirements
Module: mano_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 3, cycles from request acceptance to ack, legal range 1..15.
REQ-002 SHALL have parameter ADDRW, default `addrwidth (12), address width.
REQ-003 SHALL have parameter DATAW, default `datawidth (16), data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port clr  input  1  synchronous, active-high reset.
REQ-006 SHALL have port mem_addr  input  ADDRW  word address from cache.
REQ-007 SHALL have port mem_rd  input  1  read request, level, held until ack.
REQ-008 SHALL have port mem_wr  input  1  write request, level, held until ack.
REQ-009 SHALL have port mem_wdata  input  DATAW  write data, cache to memory.
REQ-010 SHALL have port mem_rdata  output  DATAW  read data, memory to cache.
REQ-011 SHALL have port mem_ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port mem_busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port mem_conflict  output  1  sticky flag: mem_rd and mem_wr sampled high together.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACK, DRAIN.
REQ-015 In IDLE, if mem_rd or mem_wr is high at a posedge: latch mem_addr, mem_wdata, and op type; load the counter with LATENCY-1; go to WAIT.
REQ-016 In WAIT, at a posedge with counter nonzero: decrement counter and stay in WAIT.
REQ-017 In WAIT, at a posedge with counter zero: perform the latched access and go to ACK.
REQ-018 A read SHALL register the array word into mem_rdata.
REQ-019 A write SHALL commit the latched data to the array.
REQ-020 mem_ack SHALL be high only in ACK, so it rises exactly LATENCY cycles after the accepting edge.
REQ-021 From ACK SHALL go to DRAIN.
REQ-022 DRAIN SHALL stay until mem_rd and mem_wr are both low at a posedge, then go to IDLE (four-phase handshake).
REQ-023 A request still held in DRAIN SHALL NOT be re-accepted.
REQ-024 mem_addr and mem_wdata changes after acceptance SHALL be ignored; only the latched values are used.
REQ-025 When mem_rd and mem_wr are both high at acceptance, the op SHALL be a write (write priority) and mem_conflict SHALL be set.
REQ-026 mem_rdata SHALL hold its value until the next read completes; writes SHALL NOT alter it.
REQ-027 A read following a write to the same address SHALL return the written data.
REQ-028 Counter width SHALL be 4 bits; the counter SHALL NOT wrap below zero.

Reset
REQ-029 clr high at a posedge SHALL force: state IDLE, counter 0, mem_ack 0, mem_busy 0, mem_rdata 0, mem_conflict 0.
REQ-030 clr during WAIT SHALL abort the access: no array write committed, no ack issued.
REQ-031 clr SHALL NOT clear array contents.
REQ-032 clr SHALL take priority over any simultaneous request.

Structure
REQ-033 addrwidth, datawidth, and the FSM state encodings SHALL reside in the shared basic_params definitions.
REQ-034 The storage array SHALL be a sub-module mano_ram4096x16: single-port, synchronous read and write, one access per cycle, no reset.

Verification
REQ-035 LATENCY=3; write 0x1234 to addr 0x0A5, hold mem_wr until ack -> ack exactly 3 cycles after accept; array[0x0A5]=0x1234; mem_rdata unchanged.
REQ-036 Read addr 0x0A5 after REQ-035 -> mem_rdata=0x1234 when mem_ack=1; mem_busy high from accept through DRAIN.
REQ-037 Hold mem_rd high for 6 cycles after ack -> exactly one ack; FSM stays in DRAIN until mem_rd drops, then IDLE.
REQ-038 mem_rd=mem_wr=1, addr 0x3FF, data 0xBEEF -> write performed; mem_conflict=1 until clr; a later read of 0x3FF returns 0xBEEF.
REQ-039 Start write of 0x5555 to 0x010 (old 0x0000); assert clr in WAIT -> no ack; array[0x010] stays 0x0000; all outputs at reset values.
REQ-040 LATENCY=1; change mem_addr one cycle after read accept -> ack 1 cycle after accept; data from the originally latched address.

Source files
------------

// File: rtl/basic_params_pkg.sv
// Shared widths, FSM state encodings and op codes for the Mano memory responder slice.
package basic_params;

  localparam int ADDRWIDTH = 12;
  localparam int DATAWIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/mano_ram4096x16.sv
// Single-port synchronous RAM: one read or write per cycle, registered read data, no reset.
module mano_ram4096x16 #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [0:(1<<AW)-1];
  logic [DW-1:0] rdata_r;

  // Array access; read data only updates on a read so it holds across writes
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[addr] <= wdata;
      end else begin
        rdata_r <= mem_r[addr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mano_mem_responder.sv
// Fixed-latency memory responder with a four-phase req/ack handshake in front of
// a single-port RAM; write wins when read and write are requested together.
module mano_mem_responder
  import basic_params::*;
#(
  parameter int LATENCY = 3,
  parameter int ADDRW   = ADDRWIDTH,
  parameter int DATAW   = DATAWIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [ADDRW-1:0] mem_addr,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [DATAW-1:0] mem_wdata,
  output logic [DATAW-1:0] mem_rdata,
  output logic             mem_ack,
  output logic             mem_busy,
  output logic             mem_conflict
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  state_e           state_r;
  op_e              op_r;
  logic [3:0]       cnt_r;
  logic [ADDRW-1:0] addr_r;
  logic [DATAW-1:0] wdata_r;
  logic [DATAW-1:0] rdata_r;
  logic             ack_r;
  logic             busy_r;
  logic             conflict_r;

  logic             accept_s;
  logic             rd_fetch_s;
  logic             ram_we_s;
  logic             ram_en_s;
  logic [ADDRW-1:0] ram_addr_s;
  logic [DATAW-1:0] ram_q_s;

  // The RAM read is issued ahead of the final WAIT edge (from the accept edge onward)
  // so its registered output is valid when the read result is captured into mem_rdata.
  assign accept_s   = (state_r == ST_IDLE) && (mem_rd || mem_wr);
  assign rd_fetch_s = ((state_r == ST_IDLE) && mem_rd && !mem_wr) ||
                      ((state_r == ST_WAIT) && (op_r == OP_READ));
  assign ram_we_s   = (state_r == ST_WAIT) && (cnt_r == 4'd0) && (op_r == OP_WRITE) && !clr;
  assign ram_en_s   = (rd_fetch_s || ram_we_s) && !clr;
  assign ram_addr_s = (state_r == ST_IDLE) ? mem_addr : addr_r;

  mano_ram4096x16 #(
    .AW (ADDRW),
    .DW (DATAW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en_s),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (wdata_r),
    .rdata (ram_q_s)
  );

  // Handshake FSM with latched request and registered outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r    <= ST_IDLE;
      op_r       <= OP_READ;
      cnt_r      <= 4'd0;
      addr_r     <= '0;
      wdata_r    <= '0;
      rdata_r    <= '0;
      ack_r      <= 1'b0;
      busy_r     <= 1'b0;
      conflict_r <= 1'b0;
    end else begin
      ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            addr_r     <= mem_addr;
            wdata_r    <= mem_wdata;
            op_r       <= mem_wr ? OP_WRITE : OP_READ;
            conflict_r <= conflict_r | (mem_rd & mem_wr);
            cnt_r      <= LAT_LOAD;
            busy_r     <= 1'b1;
            state_r    <= ST_WAIT;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            if (op_r == OP_READ) begin
              rdata_r <= ram_q_s;
            end
            ack_r   <= 1'b1;
            state_r <= ST_ACK;
          end
        end
        ST_ACK: begin
          state_r <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!mem_rd && !mem_wr) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_rdata    = rdata_r;
  assign mem_ack      = ack_r;
  assign mem_busy     = busy_r;
  assign mem_conflict = conflict_r;

endmodule

// File: tb/tb_mano_mem_responder.sv
// Randomized bench for mano_mem_responder at LATENCY 3 and 1 against a transaction-level memory model.
module tb_mano_mem_responder;

  logic        clk;
  logic        clr   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [11:0] addr  [2];
  logic [15:0] wdata [2];
  logic [15:0] rdata [2];
  logic        ack   [2];
  logic        busy  [2];
  logic        conf  [2];

  int          lat_tbl [2] = '{3, 1};
  logic [15:0] model [int];
  logic [15:0] exp_rdata [2];
  logic        exp_conf [2];
  int          n_checks = 0;
  int          n_fail = 0;

  mano_mem_responder #(.LATENCY(3)) dut3 (
    .clk(clk), .clr(clr[0]), .mem_addr(addr[0]), .mem_rd(rd[0]), .mem_wr(wr[0]),
    .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_ack(ack[0]), .mem_busy(busy[0]),
    .mem_conflict(conf[0])
  );

  mano_mem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .clr(clr[1]), .mem_addr(addr[1]), .mem_rd(rd[1]), .mem_wr(wr[1]),
    .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_ack(ack[1]), .mem_busy(busy[1]),
    .mem_conflict(conf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset(input int u);
    chk("rst_ack",   32'(ack[u]),   32'd0);
    chk("rst_busy",  32'(busy[u]),  32'd0);
    chk("rst_rdata", 32'(rdata[u]), 32'd0);
    chk("rst_conf",  32'(conf[u]),  32'd0);
  endtask

  // One full four-phase transaction on unit u; hold = extra cycles the request stays up after ack
  task automatic do_txn(input int u, input bit r, input bit w, input logic [11:0] a,
                        input logic [15:0] d, input int hold, input bit chg);
    int k;
    int n;
    bit seen;
    int key;
    key = u * 4096 + int'(a);
    @(negedge clk);
    rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d;
    @(posedge clk); #1;
    chk("busy_accept", 32'(busy[u]), 32'd1);
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      if (chg && k == 0) begin
        addr[u]  = a ^ 12'hFFF;
        wdata[u] = ~d;
      end
      @(posedge clk); #1;
      k++;
      if (ack[u]) seen = 1'b1;
      else chk("busy_wait", 32'(busy[u]), 32'd1);
    end
    chk("ack_seen", 32'(seen), 32'd1);
    chk("ack_latency", 32'(k), 32'(lat_tbl[u]));
    if (w) begin
      model[key] = d;
      if (r) exp_conf[u] = 1'b1;
    end else begin
      exp_rdata[u] = model[key];
    end
    chk("rdata_at_ack", 32'(rdata[u]), 32'(exp_rdata[u]));
    chk("conflict", 32'(conf[u]), 32'(exp_conf[u]));
    chk("busy_ack", 32'(busy[u]), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("ack_once", 32'(ack[u]), 32'd0);
      chk("busy_drain", 32'(busy[u]), 32'd1);
    end
    @(negedge clk);
    rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = 12'($urandom);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      chk("ack_after_drop", 32'(ack[u]), 32'd0);
    end while (busy[u] && n < 5);
    chk("busy_idle", 32'(busy[u]), 32'd0);
    chk("drain_edges", 32'(n), (hold == 0) ? 32'd2 : 32'd1);
    chk("rdata_hold", 32'(rdata[u]), 32'(exp_rdata[u]));
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      clr[u] = 1'b1; rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = 12'd0; wdata[u] = 16'd0;
      exp_rdata[u] = 16'd0; exp_conf[u] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    clr[0] = 1'b0; clr[1] = 1'b0;

    // Write then read back, long hold in drain, conflicting request
    do_txn(0, 1'b0, 1'b1, 12'h0A5, 16'h1234, 0, 1'b0);
    do_txn(0, 1'b1, 1'b0, 12'h0A5, 16'h0000, 1, 1'b0);
    do_txn(0, 1'b1, 1'b0, 12'h0A5, 16'h0000, 6, 1'b0);
    do_txn(0, 1'b1, 1'b1, 12'h3FF, 16'hBEEF, 0, 1'b0);
    do_txn(0, 1'b1, 1'b0, 12'h3FF, 16'h0000, 2, 1'b0);

    // Abort a write with clr on the edge that would commit it
    do_txn(0, 1'b0, 1'b1, 12'h010, 16'h0000, 0, 1'b0);
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 12'h010; wdata[0] = 16'h5555;
    @(posedge clk);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_no_ack", 32'(ack[0]), 32'd0);
    end
    @(negedge clk);
    clr[0] = 1'b1;
    @(posedge clk); #1;
    chk_reset(0);
    @(negedge clk);
    clr[0] = 1'b0; wr[0] = 1'b0;
    exp_rdata[0] = 16'd0; exp_conf[0] = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_ack_late", 32'(ack[0]), 32'd0);
    do_txn(0, 1'b1, 1'b0, 12'h010, 16'h0000, 0, 1'b0);
    do_txn(0, 1'b1, 1'b0, 12'h0A5, 16'h0000, 0, 1'b0);

    // LATENCY 1 with address and data changed after acceptance
    do_txn(1, 1'b0, 1'b1, 12'h0A5, 16'hA5A5, 0, 1'b1);
    do_txn(1, 1'b0, 1'b1, 12'hF5A, 16'h7777, 0, 1'b0);
    do_txn(1, 1'b1, 1'b0, 12'h0A5, 16'h0000, 0, 1'b1);

    for (int it = 0; it < 40; it++) begin
      int u;
      int op;
      logic [11:0] a;
      u  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 3));
      a  = 12'h100 + 12'($urandom_range(0, 15));
      if (op < 2 && model.exists(u * 4096 + int'(a)))
        do_txn(u, 1'b1, 1'b0, a, 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      else
        do_txn(u, (op == 3), 1'b1, a, 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    @(negedge clk);
    clr[0] = 1'b1; clr[1] = 1'b1;
    @(posedge clk); #1;
    chk_reset(0);
    chk_reset(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
